fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_pkg.sv | 12 +
 rtl/rr_select.sv | 34 +++
 rtl/fifo_wr_arbiter.sv | 139 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types for the FIFO write arbiter: FSM state encoding and
// the width of the burst beat counter.
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    localparam int BEAT_W = 8;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first set bit of req_i at or
// after start_i, wrapping. Ports: req_i, start_i -> found_o, idx_o.
module rr_select
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   start_i,
    output logic               found_o,
    output logic [IDX_W-1:0]   idx_o
);

    localparam int PW = IDX_W + 1;

    always_comb begin
        logic [PW-1:0] pos;
        pos     = '0;
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = {1'b0, start_i} + PW'(i);
            if (pos >= PW'(NUM_REQ)) begin
                pos = pos - PW'(NUM_REQ);
            end
            if (!found_o && req_i[pos[IDX_W-1:0]]) begin
                found_o = 1'b1;
                idx_o   = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ valid/ready requesters into
// one FIFO write port (W_DATA/WEN, back-pressured by FULL).
// Ports: CLK, RST (async, active-high), REQ_VALID/REQ_DATA/REQ_READY,
// W_DATA, WEN, FULL, GNT_VALID, GNT_ID.
// Define FIFO_ARB_BURST_EN to hold a grant for up to MAX_BURST beats;
// otherwise the grant is re-arbitrated after every transfer.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            REQ_VALID,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
    output logic [NUM_REQ-1:0]            REQ_READY,
    output logic [DATA_WIDTH-1:0]         W_DATA,
    output logic                          WEN,
    input  logic                          FULL,
    output logic                          GNT_VALID,
    output logic [$clog2(NUM_REQ)-1:0]    GNT_ID
);

    localparam int IW = $clog2(NUM_REQ);

    // Elaboration-time guard on the supported parameter ranges.
    if (NUM_REQ < 2 || NUM_REQ > 16 ||
        MAX_BURST < 1 || MAX_BURST > (1 << BEAT_W) - 1) begin : g_bad_cfg
        $error("fifo_wr_arbiter: parameter out of range");
    end

    arb_state_e    state_q;
    logic [IW-1:0] gnt_id_q;
    logic [IW-1:0] last_q;
    logic [IW-1:0] base;
    logic [IW-1:0] start_idx;
    logic [IW-1:0] pick;
    logic          found;
    logic          busy;
    logic          hold_vld;
    logic          xfer;
    logic          rel;

`ifdef FIFO_ARB_BURST_EN
    logic [BEAT_W-1:0] beat_q;
`endif

    assign busy     = (state_q == ST_BUSY);
    assign hold_vld = REQ_VALID[gnt_id_q];
    assign xfer     = busy && hold_vld && !FULL;

`ifdef FIFO_ARB_BURST_EN
    // Burst ends on its last beat, or early once the holder has
    // sent something and has nothing more to offer.
    assign rel = (xfer && beat_q == BEAT_W'(MAX_BURST - 1))
              || (busy && !hold_vld && beat_q != '0);
`else
    assign rel = xfer;
`endif

    // Search starts just past the most recent holder; in BUSY that
    // is the current holder, so both cases share one picker.
    always_comb begin
        base = busy ? gnt_id_q : last_q;
        if (base == IW'(NUM_REQ - 1)) begin
            start_idx = '0;
        end else begin
            start_idx = base + IW'(1);
        end
    end

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IW)
    ) u_sel (
        .req_i   (REQ_VALID),
        .start_i (start_idx),
        .found_o (found),
        .idx_o   (pick)
    );

    always_comb begin
        REQ_READY = '0;
        if (busy) begin
            REQ_READY[gnt_id_q] = !FULL;
        end
    end

    assign WEN       = xfer;
    assign W_DATA    = REQ_DATA[int'(gnt_id_q)*DATA_WIDTH +: DATA_WIDTH];
    assign GNT_VALID = busy;
    assign GNT_ID    = gnt_id_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            gnt_id_q <= '0;
            last_q   <= IW'(NUM_REQ - 1);
`ifdef FIFO_ARB_BURST_EN
            beat_q   <= '0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (found) begin
                        state_q  <= ST_BUSY;
                        gnt_id_q <= pick;
                        last_q   <= pick;
`ifdef FIFO_ARB_BURST_EN
                        beat_q   <= '0;
`endif
                    end
                end
                ST_BUSY: begin
                    if (rel) begin
                        // Hand over in the same cycle: no idle bubble.
                        if (found) begin
                            gnt_id_q <= pick;
                            last_q   <= pick;
                        end else begin
                            state_q  <= ST_IDLE;
                        end
`ifdef FIFO_ARB_BURST_EN
                        beat_q   <= '0;
`endif
                    end
`ifdef FIFO_ARB_BURST_EN
                    else if (xfer) begin
                        beat_q <= beat_q + 1'b1;
                    end
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (default params).
// Cycle tables per scenario plus a drain scoreboard with FULL stalls.
module tb_fifo_wr_arbiter;

    logic        CLK;
    logic        RST;
    logic [3:0]  REQ_VALID;
    logic [31:0] REQ_DATA;
    logic [3:0]  REQ_READY;
    logic [7:0]  W_DATA;
    logic        WEN;
    logic        FULL;
    logic        GNT_VALID;
    logic [1:0]  GNT_ID;

    fifo_wr_arbiter #(
        .DATA_WIDTH (8),
        .NUM_REQ    (4),
        .MAX_BURST  (4)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ_VALID (REQ_VALID),
        .REQ_DATA  (REQ_DATA),
        .REQ_READY (REQ_READY),
        .W_DATA    (W_DATA),
        .WEN       (WEN),
        .FULL      (FULL),
        .GNT_VALID (GNT_VALID),
        .GNT_ID    (GNT_ID)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0] vld;
        logic       full;
        logic       gv;
        logic [1:0] id;
        logic       wen;
    } vec_t;

    vec_t       vq[$];
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] dconst [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] vld, input logic full,
                       input logic gv, input logic [1:0] id,
                       input logic wen);
        vec_t v;
        v.vld  = vld;
        v.full = full;
        v.gv   = gv;
        v.id   = id;
        v.wen  = wen;
        vq.push_back(v);
    endtask

    // Assert reset mid-cycle (async drop) and check the reset outputs.
    task automatic do_reset(input logic [3:0] vld);
        @(posedge CLK);
        #1;
        RST       = 1'b1;
        REQ_VALID = vld;
        FULL      = 1'b0;
        REQ_DATA  = {dconst[3], dconst[2], dconst[1], dconst[0]};
        @(negedge CLK);
        chk("rst.gv", GNT_VALID, 0);
        chk("rst.wen", WEN, 0);
        chk("rst.rdy", REQ_READY, 0);
        chk("rst.id", GNT_ID, 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    task automatic run_vecs(input string name);
        logic [3:0] er;
        foreach (vq[k]) begin
            REQ_VALID = vq[k].vld;
            FULL      = vq[k].full;
            @(negedge CLK);
            er = '0;
            if (vq[k].gv && !vq[k].full) er[vq[k].id] = 1'b1;
            chk($sformatf("%s[%0d].gv", name, k), GNT_VALID, vq[k].gv);
            chk($sformatf("%s[%0d].wen", name, k), WEN, vq[k].wen);
            chk($sformatf("%s[%0d].rdy", name, k), REQ_READY, er);
            if (vq[k].gv)
                chk($sformatf("%s[%0d].id", name, k), GNT_ID, vq[k].id);
            if (vq[k].wen)
                chk($sformatf("%s[%0d].wd", name, k), W_DATA,
                    dconst[vq[k].id]);
            @(posedge CLK);
            #1;
        end
        vq.delete();
    endtask

    task automatic scoreboard();
        int         nw   [4] = '{3, 5, 2, 4};
        int         sent [4] = '{0, 0, 0, 0};
        int         rx   [4] = '{0, 0, 0, 0};
        logic [3:0] hs;
        logic [1:0] id;
        logic       done;
        done = 1'b0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            FULL = (cyc % 4 == 2);
            for (int i = 0; i < 4; i++) begin
                REQ_VALID[i]     = (sent[i] < nw[i]);
                REQ_DATA[i*8+:8] = {2'(i), 6'(sent[i])};
            end
            @(negedge CLK);
            hs = REQ_READY & REQ_VALID;
            chk("sb_wen", WEN, |hs);
            chk("sb_full", WEN & FULL, 0);
            if (WEN) begin
                id = W_DATA[7:6];
                chk("sb_word", W_DATA, {id, 6'(rx[id])});
                rx[id]++;
            end
            @(posedge CLK);
            #1;
            done = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (hs[i]) sent[i]++;
                if (sent[i] != nw[i]) done = 1'b0;
            end
        end
        chk("sb_drain", done, 1);
        for (int i = 0; i < 4; i++)
            chk($sformatf("sb_cnt%0d", i), rx[i], nw[i]);
    endtask

    initial begin
        RST       = 1'b1;
        REQ_VALID = '0;
        REQ_DATA  = '0;
        FULL      = 1'b0;

        // All four valid through reset, then continuous streaming.
        do_reset(4'hF);
        add(4'hF, 0, 0, 0, 0);
`ifdef FIFO_ARB_BURST_EN
        for (int i = 0; i < 4; i++) add(4'hF, 0, 1, 0, 1);
        for (int i = 0; i < 4; i++) add(4'hF, 0, 1, 1, 1);
        add(4'hF, 0, 1, 2, 1);
`else
        add(4'hF, 0, 1, 0, 1);
        add(4'hF, 0, 1, 1, 1);
        add(4'hF, 0, 1, 2, 1);
        add(4'hF, 0, 1, 3, 1);
        add(4'hF, 0, 1, 0, 1);
`endif
        run_vecs("rr4");

        // Requesters 2,3 with FULL high for three cycles.
        do_reset(4'b1100);
        add(4'b1100, 0, 0, 0, 0);
        add(4'b1100, 0, 1, 2, 1);
`ifdef FIFO_ARB_BURST_EN
        add(4'b1100, 1, 1, 2, 0);
        add(4'b1100, 1, 1, 2, 0);
        add(4'b1100, 1, 1, 2, 0);
        add(4'b1100, 0, 1, 2, 1);
        add(4'b1100, 0, 1, 2, 1);
        add(4'b1100, 0, 1, 2, 1);
        add(4'b1100, 0, 1, 3, 1);
`else
        add(4'b1100, 1, 1, 3, 0);
        add(4'b1100, 1, 1, 3, 0);
        add(4'b1100, 1, 1, 3, 0);
        add(4'b1100, 0, 1, 3, 1);
        add(4'b1100, 0, 1, 2, 1);
        add(4'b1100, 0, 1, 3, 1);
        add(4'b1100, 0, 1, 2, 1);
`endif
        run_vecs("full");

`ifdef FIFO_ARB_BURST_EN
        // Back-to-back bursts from 1 and 2.
        do_reset(4'b0110);
        add(4'b0110, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(4'b0110, 0, 1, 1, 1);
        for (int i = 0; i < 4; i++) add(4'b0110, 0, 1, 2, 1);
        add(4'b0110, 0, 1, 1, 1);
        run_vecs("burst");

        // Holder stops after two beats; nobody else waiting.
        do_reset(4'b0001);
        add(4'b0001, 0, 0, 0, 0);
        add(4'b0001, 0, 1, 0, 1);
        add(4'b0001, 0, 1, 0, 1);
        add(4'b0000, 0, 1, 0, 0);
        add(4'b0000, 0, 0, 0, 0);
        run_vecs("drop");
`endif

        do_reset(4'b0000);
        scoreboard();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
